// File: rtl/tile_search_pkg.sv
// Shared grid definitions for the tile search engine.
//   GridLen : candidates per row; default width of the index and value buses.
//   state_e : one-hot search FSM state (idle, request issued, response check).
package tile_search_pkg;

  localparam int unsigned GridLen = 9;

  typedef enum logic [2:0] {
    StIdle    = 3'b001,
    StRequest = 3'b010,
    StCheck   = 3'b100
  } state_e;

endpackage

// File: rtl/tile_search.sv
// Per-tile value search engine; requesting end of the row bias bus.
// Walks the shuffled candidate pool with one-hot index requests and commits the
// first returned value that does not collide with the peer-occupied mask.
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   start             : fresh search from index 0 (idle only)
//   resume            : continue from the index after the held one (idle only)
//   occupied[WIDTH]   : OR of peer-committed values, stable while busy
//   valtotry[WIDTH]   : one-hot candidate, valid the cycle after update
//   update            : request strobe to the responder
//   rqindex[WIDTH]    : one-hot pool index held (0 when none)
//   value[WIDTH]      : committed one-hot value (0 when uncommitted)
//   busy              : high outside idle
//   pass, fail        : one-cycle result pulses
module tile_search
  import tile_search_pkg::*;
#(
  parameter int unsigned WIDTH = GridLen
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             resume,
  input  logic [WIDTH-1:0] occupied,
  input  logic [WIDTH-1:0] valtotry,
  output logic             update,
  output logic [WIDTH-1:0] rqindex,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             pass,
  output logic             fail
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rqindex_q, rqindex_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;

  // Last pool position is held: any further advance exhausts the pool.
  logic at_last;
  assign at_last = rqindex_q[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    rqindex_d = rqindex_q;
    value_d   = value_q;
    pass_d    = 1'b0;
    fail_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A resume with no held position is a fresh start.
        if (start || (resume && rqindex_q == '0)) begin
          rqindex_d = WIDTH'(1);
          value_d   = '0;
          state_d   = StRequest;
        end else if (resume) begin
          value_d = '0;
          if (at_last) begin
            rqindex_d = '0;
            fail_d    = 1'b1;
          end else begin
            rqindex_d = rqindex_q << 1;
            state_d   = StRequest;
          end
        end
      end
      StRequest: begin
        state_d = StCheck;
      end
      StCheck: begin
        if ((valtotry & occupied) == '0) begin
          value_d = valtotry;
          pass_d  = 1'b1;
          state_d = StIdle;
        end else if (at_last) begin
          rqindex_d = '0;
          value_d   = '0;
          fail_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          rqindex_d = rqindex_q << 1;
          state_d   = StRequest;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      rqindex_q <= '0;
      value_q   <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rqindex_q <= rqindex_d;
      value_q   <= value_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign update  = (state_q == StRequest);
  assign busy    = (state_q != StIdle);
  assign rqindex = rqindex_q;
  assign value   = value_q;
  assign pass    = pass_q;
  assign fail    = fail_q;

endmodule

// File: tb/tb_tile_search.sv
// Directed bench for tile_search at WIDTH = 4 with a fixed-pool stub responder.
module tb_tile_search;

  logic       clock;
  logic       reset;
  logic       start;
  logic       resume;
  logic [3:0] occupied;
  logic [3:0] valtotry;
  logic       update;
  logic [3:0] rqindex;
  logic [3:0] value;
  logic       busy;
  logic       pass;
  logic       fail;

  int tests = 0;
  int fails = 0;

  tile_search #(.WIDTH(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .resume   (resume),
    .occupied (occupied),
    .valtotry (valtotry),
    .update   (update),
    .rqindex  (rqindex),
    .value    (value),
    .busy     (busy),
    .pass     (pass),
    .fail     (fail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stub pool: index0->0100, index1->0001, index2->1000, index3->0010.
  function automatic logic [3:0] pool(input logic [3:0] idx);
    case (idx)
      4'b0001: pool = 4'b0100;
      4'b0010: pool = 4'b0001;
      4'b0100: pool = 4'b1000;
      4'b1000: pool = 4'b0010;
      default: pool = 4'b0000;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) valtotry <= 4'b0;
    else if (update) valtotry <= pool(rqindex);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests += 6;
    if (update !== 1'b0)   begin fails++; $display("FAIL reset_update got %b want 0", update); end
    if (rqindex !== 4'b0)  begin fails++; $display("FAIL reset_rqindex got %b want 0000", rqindex); end
    if (value !== 4'b0)    begin fails++; $display("FAIL reset_value got %b want 0000", value); end
    if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    if (pass !== 1'b0)     begin fails++; $display("FAIL reset_pass got %b want 0", pass); end
    if (fail !== 1'b0)     begin fails++; $display("FAIL reset_fail got %b want 0", fail); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_first_hit();
    occupied = 4'b0000;
    start = 1'b1;
    step();  // cycle 1
    start = 1'b0;
    tests += 3;
    if (update !== 1'b1)     begin fails++; $display("FAIL first_update got %b want 1", update); end
    if (rqindex !== 4'b0001) begin fails++; $display("FAIL first_rqindex got %b want 0001", rqindex); end
    if (busy !== 1'b1)       begin fails++; $display("FAIL first_busy got %b want 1", busy); end
    step();  // cycle 2
    tests += 2;
    if (update !== 1'b0) begin fails++; $display("FAIL first_update_c2 got %b want 0", update); end
    if (pass !== 1'b0)   begin fails++; $display("FAIL first_pass_c2 got %b want 0", pass); end
    step();  // cycle 3
    tests += 4;
    if (pass !== 1'b1)     begin fails++; $display("FAIL first_pass got %b want 1", pass); end
    if (fail !== 1'b0)     begin fails++; $display("FAIL first_fail got %b want 0", fail); end
    if (value !== 4'b0100) begin fails++; $display("FAIL first_value got %b want 0100", value); end
    if (busy !== 1'b0)     begin fails++; $display("FAIL first_busy_c3 got %b want 0", busy); end
    step();
    tests++;
    if (pass !== 1'b0) begin fails++; $display("FAIL first_pass_pulse got %b want 0", pass); end
  endtask

  task automatic test_walk();
    logic       exp_upd;
    logic [3:0] exp_rq;
    occupied = 4'b0101;
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      start = 1'b0;
      exp_upd = (c % 2 == 1) && (c < 7);
      exp_rq  = 4'(1 << ((c - 1) / 2));
      tests += 2;
      if (update !== exp_upd) begin
        fails++; $display("FAIL walk_update c%0d got %b want %b", c, update, exp_upd);
      end
      if (pass !== (c == 7)) begin
        fails++; $display("FAIL walk_pass c%0d got %b want %b", c, pass, (c == 7));
      end
      if (exp_upd) begin
        tests++;
        if (rqindex !== exp_rq) begin
          fails++; $display("FAIL walk_rqindex c%0d got %b want %b", c, rqindex, exp_rq);
        end
      end
    end
    tests += 2;
    if (value !== 4'b1000)   begin fails++; $display("FAIL walk_value got %b want 1000", value); end
    if (rqindex !== 4'b0100) begin fails++; $display("FAIL walk_rq_held got %b want 0100", rqindex); end
  endtask

  task automatic test_resume();
    resume = 1'b1;
    step();  // cycle 1
    resume = 1'b0;
    tests += 3;
    if (update !== 1'b1)     begin fails++; $display("FAIL resume_update got %b want 1", update); end
    if (rqindex !== 4'b1000) begin fails++; $display("FAIL resume_rqindex got %b want 1000", rqindex); end
    if (value !== 4'b0000)   begin fails++; $display("FAIL resume_value_clr got %b want 0000", value); end
    step();
    step();  // cycle 3
    tests += 2;
    if (pass !== 1'b1)     begin fails++; $display("FAIL resume_pass got %b want 1", pass); end
    if (value !== 4'b0010) begin fails++; $display("FAIL resume_value got %b want 0010", value); end
  endtask

  task automatic test_exhaust();
    logic exp_upd;
    occupied = 4'b1111;
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      start = 1'b0;
      exp_upd = (c % 2 == 1) && (c < 9);
      tests += 3;
      if (update !== exp_upd) begin
        fails++; $display("FAIL exh_update c%0d got %b want %b", c, update, exp_upd);
      end
      if (fail !== (c == 9)) begin
        fails++; $display("FAIL exh_fail c%0d got %b want %b", c, fail, (c == 9));
      end
      if (pass !== 1'b0) begin
        fails++; $display("FAIL exh_pass c%0d got %b want 0", c, pass);
      end
    end
    tests += 2;
    if (value !== 4'b0000)   begin fails++; $display("FAIL exh_value got %b want 0000", value); end
    if (rqindex !== 4'b0000) begin fails++; $display("FAIL exh_rqindex got %b want 0000", rqindex); end
    resume = 1'b1;
    step();
    resume = 1'b0;
    tests += 2;
    if (update !== 1'b1)     begin fails++; $display("FAIL exh_restart_upd got %b want 1", update); end
    if (rqindex !== 4'b0001) begin fails++; $display("FAIL exh_restart_rq got %b want 0001", rqindex); end
    repeat (8) step();
    tests++;
    if (fail !== 1'b1) begin fails++; $display("FAIL exh_restart_fail got %b want 1", fail); end
  endtask

  task automatic test_immediate_fail();
    occupied = 4'b1101;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();  // cycle 9
    tests += 2;
    if (pass !== 1'b1)       begin fails++; $display("FAIL imm_setup_pass got %b want 1", pass); end
    if (rqindex !== 4'b1000) begin fails++; $display("FAIL imm_setup_rq got %b want 1000", rqindex); end
    resume = 1'b1;
    step();
    resume = 1'b0;
    tests += 5;
    if (fail !== 1'b1)       begin fails++; $display("FAIL imm_fail got %b want 1", fail); end
    if (update !== 1'b0)     begin fails++; $display("FAIL imm_update got %b want 0", update); end
    if (value !== 4'b0000)   begin fails++; $display("FAIL imm_value got %b want 0000", value); end
    if (rqindex !== 4'b0000) begin fails++; $display("FAIL imm_rqindex got %b want 0000", rqindex); end
    if (busy !== 1'b0)       begin fails++; $display("FAIL imm_busy got %b want 0", busy); end
    step();
    tests += 2;
    if (update !== 1'b0) begin fails++; $display("FAIL imm_update_c2 got %b want 0", update); end
    if (fail !== 1'b0)   begin fails++; $display("FAIL imm_fail_pulse got %b want 0", fail); end
  endtask

  task automatic test_busy_and_reset();
    occupied = 4'b1111;
    start = 1'b1;
    step();  // cycle 1, REQUEST
    resume = 1'b1;
    step();  // cycle 2, CHECK
    step();  // cycle 3, REQUEST for index 1
    start  = 1'b0;
    resume = 1'b0;
    tests += 2;
    if (update !== 1'b1)     begin fails++; $display("FAIL busy_update got %b want 1", update); end
    if (rqindex !== 4'b0010) begin fails++; $display("FAIL busy_rqindex got %b want 0010", rqindex); end
    occupied = 4'b1110;  // index1 would pass if not reset
    step();  // cycle 4, CHECK
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_check got %b want 1", busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests += 6;
    if (update !== 1'b0)  begin fails++; $display("FAIL rst_mid_update got %b want 0", update); end
    if (rqindex !== 4'b0) begin fails++; $display("FAIL rst_mid_rqindex got %b want 0000", rqindex); end
    if (value !== 4'b0)   begin fails++; $display("FAIL rst_mid_value got %b want 0000", value); end
    if (busy !== 1'b0)    begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    if (pass !== 1'b0)    begin fails++; $display("FAIL rst_mid_pass got %b want 0", pass); end
    if (fail !== 1'b0)    begin fails++; $display("FAIL rst_mid_fail got %b want 0", fail); end
    for (int c = 0; c < 6; c++) begin
      step();
      tests += 2;
      if (pass !== 1'b0) begin fails++; $display("FAIL rst_no_pass c%0d got %b want 0", c, pass); end
      if (busy !== 1'b0) begin fails++; $display("FAIL rst_idle c%0d got %b want 0", c, busy); end
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    resume   = 1'b0;
    occupied = 4'b0;
    test_reset();
    test_first_hit();
    test_walk();
    test_resume();
    test_exhaust();
    test_immediate_fail();
    test_busy_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tile_search.md
# tile_search

Per-tile value search engine; the requesting end of the `rowbias` bias bus. On command it walks the row's shuffled candidate pool by issuing one-hot `rqindex` requests, tests each returned `valtotry` against the peer-occupied mask, and either commits the first non-conflicting value (pass) or exhausts the pool (fail). One instance per tile; every tile in a row shares one `rowbias` responder.

## Interface
- `WIDTH`, default `` `GRID_LEN ``, candidate count; also the width of the index and value buses.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a fresh search from index 0; accepted only in IDLE.
- `resume`  in  1  backtrack re-entry: continue from the index after the current one; accepted only in IDLE.
- `occupied`  in  WIDTH  OR of values committed by row/column/block peers; must be stable while `busy`.
- `valtotry`  in  WIDTH  one-hot candidate from `rowbias`; valid the cycle after `update`.
- `update`  out  1  request strobe to `rowbias`.
- `rqindex`  out  WIDTH  one-hot pool index; 0 when no search position is held.
- `value`  out  WIDTH  committed one-hot value; 0 when uncommitted.
- `busy`  out  1  high outside IDLE.
- `pass`  out  1  one-cycle pulse: a value is committed.
- `fail`  out  1  one-cycle pulse: pool exhausted; `value` = 0, `rqindex` = 0.

## Operation
- States: IDLE, REQUEST, CHECK.
- IDLE:
  - `start` sets `rqindex` to 1, clears `value`, and moves to REQUEST.
  - `resume` with `rqindex` = 0 behaves exactly as `start`.
  - `resume` with `rqindex[WIDTH-1]` set clears `value` and `rqindex`, pulses `fail`, stays in IDLE, and issues no `update`.
  - Any other `resume` shifts `rqindex` left by 1, clears `value`, and moves to REQUEST.
  - `start` and `resume` together: `start` wins.
- REQUEST: `update` = 1 with the held `rqindex`; go to CHECK.
- CHECK: `update` = 0; sample `valtotry` and `occupied`.
  - `(valtotry & occupied) == 0`: `value` <= `valtotry`, pulse `pass`, go to IDLE; `rqindex` is retained for a later `resume`.
  - Conflict with `rqindex[WIDTH-1]` set: `rqindex` <= 0, `value` <= 0, pulse `fail`, go to IDLE.
  - Conflict otherwise: `rqindex` <<= 1, go to REQUEST.
- `start` and `resume` are ignored while `busy`.
- `pass` and `fail` are never high together.
- `valtotry` is treated as one-hot. A zero or non-one-hot `valtotry` is outside the contract and yields undefined `value`.

## Timing
- Reset, including mid-search: next cycle state = IDLE, and `update`, `rqindex`, `value`, `busy`, `pass`, `fail` are all 0.
- Cycle 0: `start` sampled. Cycle 1: REQUEST, `update` high. Cycle 2: CHECK. Cycle 3: `pass`/`fail` visible, `busy` low.
- Each try costs 2 cycles. Try k (0-based) resolves with `pass`/`fail` visible at cycle 2k+3.
- Worst case with `WIDTH` tries: result at cycle 2·WIDTH+1.
- Immediate-fail `resume`: `fail` visible 1 cycle after sampling.
- `rowbias` responds the edge after `update`, so `valtotry` is sampled exactly in CHECK. No other handshake exists.
- `value` and `rqindex` are registered and change only on the edges defined above.

## Structure
- Shared grid package holds:
  - the state enum, one-hot encoded: IDLE, REQUEST, CHECK;
  - the `GRID_LEN`-derived width constant.
- No sub-module: the conflict test is one AND-reduce and the index advance is one shift, both inline.
- Bench pairs the block with a stub responder that has a fixed pool, not a live `rowbias`.

## Test plan
All scenarios use `WIDTH` = 4 with stub pool index0→0100, index1→0001, index2→1000, index3→0010.
- `occupied` = 0000, `start` at cycle 0 → `update` only at cycle 1 with `rqindex` 0001; `pass` at cycle 3; `value` 0100.
- `occupied` = 0101, `start` → indices 0001, 0010, 0100 requested at cycles 1, 3, 5; `pass` at cycle 7; `value` 1000; `rqindex` 0100.
- Continue from the previous case, `occupied` still 0101, `resume` → `rqindex` 1000 requested; `pass` 3 cycles after `resume`; `value` 0010.
- `occupied` = 1111, `start` → four requests; `fail` at cycle 9; `value` 0000; `rqindex` 0000. A following `resume` restarts from 0001.
- Held `rqindex` 1000 in IDLE, `resume` → `fail` next cycle, no `update`, `value` 0000.
- Assert `start` and `resume` while `busy` → both ignored. Then assert `reset` during CHECK → next cycle all outputs 0, and no `pass` pulse ever appears.
